ram_nway: RTL and testbench

//   Parametrised RAM of DEPTH words, each WIDTH bits, for the Hack memory path.

---
 rtl/ram_nway.sv | 101 ++++++++++
 tb/tb_ram_nway.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_nway.sv
// ram_nway: DEPTH x WIDTH Hack RAM. A DMux-N tree decodes load into per-word enables and a Mux-N tree selects the read word.
// Latency: the read is combinational with 0 cycles. When RAM_NWAY_READ_REG_EN is defined, the read is registered with 1 cycle and is write-first.
// Backpressure: none. Every edge with load=1 writes, and rst overrides load.
module ram_nway #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  // Storage, one entry per word.
  logic [WIDTH-1:0] mem [DEPTH];

  // Per-word write enables produced by the DMux tree. At most one bit is set.
  logic [DEPTH-1:0] word_en;
  logic [DEPTH-1:0] dec_cur;
  logic [DEPTH-1:0] dec_nxt;

  // Read word selected by the Mux tree.
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] mux_cur [DEPTH];
  logic [WIDTH-1:0] mux_nxt [DEPTH];

  // DMux-N tree. The root splits load on the address MSB, and each later level
  // splits every live node on the next lower bit. Node j at a level stands for
  // address prefix j, and its children are 2j (bit=0) and 2j+1 (bit=1). After
  // the last level, the leaf index equals the word index. Nodes outside the
  // current level stay 0, so their children are also 0.
  always_comb begin
    dec_cur    = '0;
    dec_nxt    = '0;
    dec_cur[0] = load;
    for (int lvl = 0; lvl < ADDR_W; lvl++) begin
      for (int j = 0; j < DEPTH / 2; j++) begin
        dec_nxt[2*j]   = dec_cur[j] & ~address[ADDR_W-1-lvl];
        dec_nxt[2*j+1] = dec_cur[j] &  address[ADDR_W-1-lvl];
      end
      dec_cur = dec_nxt;
    end
    word_en = dec_cur;
  end

  // Mux-N tree. It starts from the leaves (the words) and halves the node count
  // at each level. The deepest level selects on address[0] and the root selects
  // on the MSB, which mirrors the decode order. Entries past the live half of
  // each level are stale and never read.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mux_cur[i] = mem[i];
      mux_nxt[i] = '0;
    end
    for (int lvl = ADDR_W - 1; lvl >= 0; lvl--) begin
      for (int j = 0; j < DEPTH / 2; j++) begin
        mux_nxt[j] = address[ADDR_W-1-lvl] ? mux_cur[2*j+1] : mux_cur[2*j];
      end
      mux_cur = mux_nxt;
    end
    rd_word = mux_cur[0];
  end

  // Word update. Reset clears every word in one edge and wins over any write in
  // that cycle, so X on load/address during reset cannot reach storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_en[i]) begin
          mem[i] <= in;
        end
      end
    end
  end

`ifdef RAM_NWAY_READ_REG_EN
  // Registered read, write-first. out takes the value the addressed word holds
  // after this edge, which is the incoming data whenever load is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end else begin
      out <= rd_word;
    end
  end
`else
  // Combinational read with Hack semantics. During a write, the old word is
  // visible until the edge.
  assign out = rd_word;
`endif

endmodule

// File: tb/tb_ram_nway.sv
// tb_ram_nway: directed vectors on an 8x16 RAM and a 64x8 RAM, with scoreboard checking.
// Stimulus drives inputs #1 after posedge and queues hand-computed expected reads.
// A negedge monitor pops the queue and compares out whenever a check is strobed.
`timescale 1ns/1ps
module tb_ram_nway;

  logic        clk;
  logic        rst;
  logic [15:0] in_s;
  logic        load_s;
  logic [2:0]  addr_s;
  logic [15:0] out_s;
  logic [7:0]  in_b;
  logic        load_b;
  logic [5:0]  addr_b;
  logic [7:0]  out_b;

  ram_nway #(.WIDTH(16), .DEPTH(8)) u_small (
    .clk(clk), .rst(rst), .in(in_s), .load(load_s), .address(addr_s), .out(out_s)
  );

  ram_nway #(.WIDTH(8), .DEPTH(64)) u_big (
    .clk(clk), .rst(rst), .in(in_b), .load(load_b), .address(addr_b), .out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          big;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  bit   chk;
  int   n_checks;
  int   n_fail;

  // Monitor: on a strobed negedge, pop one expectation and compare it with the chosen DUT.
  always @(negedge clk) begin
    if (chk) begin
      exp_t        e;
      logic [15:0] act;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: strobe with empty queue");
      end else begin
        e   = sb_q.pop_front();
        act = e.big ? {8'h00, out_b} : out_s;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step(input bit big, input int a, input logic ld, input logic [15:0] d);
    @(posedge clk);
    #1;
    if (big) begin
      addr_b = a[5:0];
      load_b = ld;
      in_b   = d[7:0];
    end else begin
      addr_s = a[2:0];
      load_s = ld;
      in_s   = d;
    end
  endtask

  task automatic exp_now(input bit big, input logic [15:0] e, input string nm);
    sb_q.push_back('{big, e, nm});
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic wr(input bit big, input int a, input logic [15:0] d);
    step(big, a, 1'b1, d);
  endtask

  task automatic rd(input bit big, input int a, input logic [15:0] e, input string nm);
    step(big, a, 1'b0, 16'h0000);
`ifdef RAM_NWAY_READ_REG_EN
    @(posedge clk);
    #1;
`endif
    exp_now(big, e, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk      = 1'b0;
    rst      = 1'b1;
    in_s     = '0;
    load_s   = 1'b0;
    addr_s   = '0;
    in_b     = '0;
    load_b   = 1'b0;
    addr_b   = '0;

    // Reset state, then sweep all words with load=0.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_now(1'b0, 16'h0000, "rst_out_small");
    exp_now(1'b1, 16'h0000, "rst_out_big");
    for (int a = 0; a < 8; a++) rd(1'b0, a, 16'h0000, $sformatf("rst_sweep_%0d", a));

    // Two writes, then reads that include the untouched words.
    wr(1'b0, 3, 16'hA5A5);
    wr(1'b0, 7, 16'h0001);
    rd(1'b0, 3, 16'hA5A5, "wr_rd_3");
    rd(1'b0, 7, 16'h0001, "wr_rd_7");
    rd(1'b0, 0, 16'h0000, "wr_rd_0");
    rd(1'b0, 1, 16'h0000, "undisturbed_1");
    rd(1'b0, 2, 16'h0000, "undisturbed_2");
    rd(1'b0, 4, 16'h0000, "undisturbed_4");
    rd(1'b0, 5, 16'h0000, "undisturbed_5");
    rd(1'b0, 6, 16'h0000, "undisturbed_6");

    // Write-read timing around the edge.
`ifdef RAM_NWAY_READ_REG_EN
    step(1'b0, 3, 1'b1, 16'h1234);
    step(1'b0, 7, 1'b0, 16'h0000);
    exp_now(1'b0, 16'h1234, "wf_after_edge");
    step(1'b0, 7, 1'b0, 16'h0000);
    exp_now(1'b0, 16'h0001, "addr_chg_one_edge");
`else
    step(1'b0, 3, 1'b1, 16'h1234);
    exp_now(1'b0, 16'hA5A5, "old_before_edge");
    step(1'b0, 3, 1'b0, 16'h0000);
    exp_now(1'b0, 16'h1234, "new_after_edge");
    step(1'b0, 7, 1'b0, 16'h0000);
    exp_now(1'b0, 16'h0001, "addr_chg_comb");
`endif
    rd(1'b0, 3, 16'h1234, "rd_3_updated");

    // Data passes unmodified and the MSB is not sign-extended.
    wr(1'b0, 1, 16'h8000);
    rd(1'b0, 1, 16'h8000, "msb_data");

    // A write in the same cycle as reset is dropped, and all words clear.
    @(posedge clk);
    #1;
    addr_s = 3'd5;
    load_s = 1'b1;
    in_s   = 16'hFFFF;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    load_s = 1'b0;
    rd(1'b0, 5, 16'h0000, "rst_wins_5");
    rd(1'b0, 3, 16'h0000, "rst_clr_3");
    rd(1'b0, 7, 16'h0000, "rst_clr_7");
    rd(1'b0, 1, 16'h0000, "rst_clr_1");

    // Writes resume on the first edge after reset.
    wr(1'b0, 5, 16'hBEEF);
    rd(1'b0, 5, 16'hBEEF, "resume_5");
    rd(1'b0, 4, 16'h0000, "resume_4");

    // Unknown load/address during reset must not leave any word corrupt.
    wr(1'b0, 2, 16'h00F0);
    rd(1'b0, 2, 16'h00F0, "pre_x_2");
    @(posedge clk);
    #1;
    rst    = 1'b1;
    addr_s = 'x;
    load_s = 'x;
    in_s   = 16'hFFFF;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    load_s = 1'b0;
    addr_s = 3'd0;
    rd(1'b0, 2, 16'h0000, "x_rst_2");
    rd(1'b0, 5, 16'h0000, "x_rst_5");

    // 64x8 instance: write i to word i, then read every word back.
    for (int i = 0; i < 64; i++) wr(1'b1, i, i[15:0]);
    for (int i = 0; i < 64; i++) rd(1'b1, i, i[15:0], $sformatf("big_rd_%0d", i));

    step(1'b0, 0, 1'b0, 16'h0000);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
